// File: rtl/seven_segment_to_binary.sv
// rtl/seven_segment_to_binary.sv - debounced 7-segment pattern to hex digit decoder
module seven_segment_to_binary #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Enable,
  input  logic                     i_Segment_A,
  input  logic                     i_Segment_B,
  input  logic                     i_Segment_C,
  input  logic                     i_Segment_D,
  input  logic                     i_Segment_E,
  input  logic                     i_Segment_F,
  input  logic                     i_Segment_G,
  output logic [3:0]               o_Binary_Num,
  output logic                     o_Valid,
  output logic                     o_Blank,
  output logic                     o_Error,
  output logic                     o_Locked,
  output logic [ERR_CNT_WIDTH-1:0] o_Error_Count
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t     r_State;
  logic [6:0] seg_in;
  logic [6:0] r_Seg;
  logic [6:0] r_Last_Seg;
  logic       r_Last_Vld;
  logic [7:0] r_Cnt;
  logic       seg_same;
  logic       dec_legal;
  logic [3:0] dec_digit;

  assign seg_in   = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                     i_Segment_E, i_Segment_F, i_Segment_G};
  assign seg_same = (seg_in == r_Seg);

  // Blank (7'h00) is not a digit; it is handled separately at lock time.
  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'h0;
    case (r_Seg)
      7'h7E: dec_digit = 4'h0;
      7'h30: dec_digit = 4'h1;
      7'h6D: dec_digit = 4'h2;
      7'h79: dec_digit = 4'h3;
      7'h33: dec_digit = 4'h4;
      7'h5B: dec_digit = 4'h5;
      7'h5F: dec_digit = 4'h6;
      7'h70: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h7B: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h1F: dec_digit = 4'hB;
      7'h4E: dec_digit = 4'hC;
      7'h3D: dec_digit = 4'hD;
      7'h4F: dec_digit = 4'hE;
      7'h47: dec_digit = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State       <= SETTLE;
      r_Seg         <= 7'h00;
      r_Last_Seg    <= 7'h00;
      r_Last_Vld    <= 1'b0;
      r_Cnt         <= 8'd0;
      o_Binary_Num  <= 4'h0;
      o_Valid       <= 1'b0;
      o_Blank       <= 1'b0;
      o_Error       <= 1'b0;
      o_Locked      <= 1'b0;
      o_Error_Count <= '0;
    end else begin
      r_Seg   <= seg_in;
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      if (!i_Enable) begin
        r_Cnt    <= 8'd0;
        r_State  <= SETTLE;
        o_Locked <= 1'b0;
      end else begin
        if (!seg_same)
          r_Cnt <= 8'd1;
        else if (r_Cnt != STABLE)
          r_Cnt <= r_Cnt + 8'd1;

        case (r_State)
          SETTLE: begin
            // Lock only if the pattern that satisfied the count is still present.
            if (r_Cnt == STABLE && seg_same) begin
              r_State    <= LOCKED;
              o_Locked   <= 1'b1;
              r_Last_Seg <= r_Seg;
              r_Last_Vld <= 1'b1;
              if (!(r_Last_Vld && r_Last_Seg == r_Seg)) begin
                if (r_Seg == 7'h00) begin
                  o_Blank <= 1'b1;
                end else if (dec_legal) begin
                  o_Binary_Num <= dec_digit;
                  o_Valid      <= 1'b1;
                  o_Blank      <= 1'b0;
                end else begin
                  o_Error <= 1'b1;
                  o_Blank <= 1'b0;
                  if (o_Error_Count != '1)
                    o_Error_Count <= o_Error_Count + ERR_CNT_WIDTH'(1);
                end
              end
            end
          end
          LOCKED: begin
            if (!seg_same) begin
              r_State  <= SETTLE;
              o_Locked <= 1'b0;
            end
          end
          default: begin
            r_State  <= SETTLE;
            o_Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
